compare_unit: RTL and testbench
===============================

COMPARE_UNIT -- requirements
Module: compare_unit

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 20, operand width in bits.
- REQ-002: The block SHALL have parameter CHUNK, default 4, bits compared per cycle; WIDTH SHALL be a multiple of CHUNK, with NCHUNK = WIDTH/CHUNK.
- REQ-003: The block SHALL use one clock; reset is synchronous and active-low.
- REQ-004: clk, input, 1: sole clock, all state updates on rising edge.
- REQ-005: rst_n, input, 1: synchronous active-low reset.
- REQ-006: start, input, 1: request a comparison; sampled only in IDLE.
- REQ-007: register_A, input, WIDTH: first operand; sampled with start.
- REQ-008: register_B, input, WIDTH: second operand; sampled with start.
- REQ-009: op, input, 3: operation code; sampled with start.
- REQ-010: signed_mode, input, 1: two's-complement compare; present only with CMP_SIGNED_EN.
- REQ-011: busy, output, 1: high in SCAN and DONE.
- REQ-012: done, output, 1: one-cycle pulse, result valid.
- REQ-013: sign_flag, output, 1: result of the selected op.
- REQ-014: gt_flag, eq_flag, lt_flag, outputs, 1 each: one-hot magnitude relation A vs B.

Function
- REQ-015: The FSM SHALL have states IDLE, SCAN and DONE.
- REQ-016: IDLE with start=1 SHALL latch the operands and op, clear the chunk index to 0 and enter SCAN next cycle.
- REQ-017: Each SCAN cycle SHALL compare chunk i (i=0 is MSB chunk) of the latched operands.
- REQ-018: On the first unequal chunk, SCAN SHALL set gt_flag or lt_flag and enter DONE (early termination).
- REQ-019: If chunk NCHUNK-1 is equal, SCAN SHALL set eq_flag and enter DONE.
- REQ-020: DONE SHALL assert done for exactly one cycle and then return to IDLE.
- REQ-021: Latency from the start-sampling edge to done high SHALL be (index of first differing chunk)+2 cycles; equal operands SHALL take NCHUNK+1 cycles.
- REQ-022: op encoding SHALL be 0 GT, 1 LT, 2 EQ, 3 NE, 4 GE, 5 LE; the reserved codes 6 and 7 SHALL yield sign_flag=0.
- REQ-023: sign_flag and the relation flags SHALL update in the cycle done rises.
- REQ-024: sign_flag and the relation flags SHALL hold until the next accepted start, at which point all of them clear to 0.
- REQ-025: start while busy SHALL be ignored, with no queuing.
- REQ-026: Input changes after the start-sampling edge SHALL NOT affect the result in progress.

Reset
- REQ-027: rst_n=0 at a clock edge SHALL force IDLE and set busy, done, sign_flag, gt_flag, eq_flag and lt_flag to 0, including mid-SCAN.
- REQ-028: An operation aborted by reset SHALL produce no done pulse.

Configuration
- REQ-029: With CMP_SIGNED_EN defined, when signed_mode=1 at start, the block SHALL invert the MSB of both operands at latch time, then compare unsigned.
- REQ-030: Without CMP_SIGNED_EN, the signed_mode port SHALL be absent and all compares SHALL be unsigned.

Structure
- REQ-031: Package cmp_pkg SHALL hold the op code constants and the FSM state typedef.
- REQ-032: Sub-module cmp_chunk (combinational, CHUNK-bit, gt/eq/lt outputs) SHALL be the single instantiated child.

Verification
- REQ-033: A=ABCDE, B=54321, op=GT -> done 2 cycles after start, sign_flag=1, gt_flag=1.
- REQ-034: A=54321, B=ABCDE, op=GT -> sign_flag=0, lt_flag=1; the same operands with op=LE -> sign_flag=1.
- REQ-035: A=B=12345, op=EQ -> done 6 cycles after start, eq_flag=1, sign_flag=1; the same operands with op=NE -> sign_flag=0.
- REQ-036: With CMP_SIGNED_EN, A=80000, B=00001, op=GT: signed_mode=1 -> sign_flag=0; signed_mode=0 -> sign_flag=1.
- REQ-037: Second start pulse during SCAN with different operands -> ignored, and the result matches the first operands.
- REQ-038: rst_n=0 during the second SCAN cycle -> next cycle IDLE, busy=0, all flags 0, and no done pulse.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared op codes, FSM state type and op-to-flag mapping for compare_unit.
package cmp_pkg;

    localparam logic [2:0] OP_GT = 3'd0;
    localparam logic [2:0] OP_LT = 3'd1;
    localparam logic [2:0] OP_EQ = 3'd2;
    localparam logic [2:0] OP_NE = 3'd3;
    localparam logic [2:0] OP_GE = 3'd4;
    localparam logic [2:0] OP_LE = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reserved codes 6 and 7 fall through to 0.
    function automatic logic op_result(input logic [2:0] op, input logic gt,
                                       input logic eq, input logic lt);
        case (op)
            OP_GT:   return gt;
            OP_LT:   return lt;
            OP_EQ:   return eq;
            OP_NE:   return ~eq;
            OP_GE:   return gt | eq;
            OP_LE:   return lt | eq;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational magnitude compare of one CHUNK-bit slice.
module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/compare_unit.sv
// Multi-cycle MSB-first chunked comparator with early termination.
// Optional two's-complement mode enabled by defining CMP_SIGNED_EN.
module compare_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] register_A,
    input  logic [WIDTH-1:0] register_B,
    input  logic [2:0]       op,
`ifdef CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             sign_flag,
    output logic             gt_flag,
    output logic             eq_flag,
    output logic             lt_flag
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [IDX_W-1:0] idx;
    logic             res_gt;
    logic             res_eq;
    logic             res_lt;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             c_gt;
    logic             c_eq;
    logic             c_lt;
    logic [WIDTH-1:0] msb_flip;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
`ifdef CMP_SIGNED_EN
    assign msb_flip = signed_mode ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
`else
    assign msb_flip = '0;
`endif

    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDX_W'(k)) begin
                chunk_a = a_q[WIDTH-1-k*CHUNK -: CHUNK];
                chunk_b = b_q[WIDTH-1-k*CHUNK -: CHUNK];
            end
        end
    end

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (chunk_a),
        .b  (chunk_b),
        .gt (c_gt),
        .eq (c_eq),
        .lt (c_lt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sign_flag <= 1'b0;
            gt_flag   <= 1'b0;
            eq_flag   <= 1'b0;
            lt_flag   <= 1'b0;
            idx       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= register_A ^ msb_flip;
                        b_q       <= register_B ^ msb_flip;
                        op_q      <= op;
                        idx       <= '0;
                        busy      <= 1'b1;
                        sign_flag <= 1'b0;
                        gt_flag   <= 1'b0;
                        eq_flag   <= 1'b0;
                        lt_flag   <= 1'b0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (!c_eq) begin
                        res_gt <= c_gt;
                        res_lt <= c_lt;
                        res_eq <= 1'b0;
                        state  <= DONE;
                    end else if (idx == LAST_IDX) begin
                        res_gt <= 1'b0;
                        res_lt <= 1'b0;
                        res_eq <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // Result is published together with the done pulse.
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    gt_flag   <= res_gt;
                    eq_flag   <= res_eq;
                    lt_flag   <= res_lt;
                    sign_flag <= op_result(op_q, res_gt, res_eq, res_lt);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_compare_unit.sv
// Scoreboard bench for compare_unit: directed vectors, monitor checks each done pulse.
module tb_compare_unit;
    import cmp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] register_A;
    logic [19:0] register_B;
    logic [2:0]  op;
`ifdef CMP_SIGNED_EN
    logic        signed_mode;
`endif
    logic        busy;
    logic        done;
    logic        sign_flag;
    logic        gt_flag;
    logic        eq_flag;
    logic        lt_flag;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic s;
        logic g;
        logic e;
        logic l;
        time  t;
    } exp_t;

    exp_t q[$];

    compare_unit #(.WIDTH(20), .CHUNK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .register_A (register_A),
        .register_B (register_B),
        .op         (op),
`ifdef CMP_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .busy       (busy),
        .done       (done),
        .sign_flag  (sign_flag),
        .gt_flag    (gt_flag),
        .eq_flag    (eq_flag),
        .lt_flag    (lt_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected actual=1 required=0 at t=%0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_time", 64'($time), 64'(e.t));
                chk("sign_flag", 64'(sign_flag), 64'(e.s));
                chk("rel_flags", 64'({gt_flag, eq_flag, lt_flag}), 64'({e.g, e.e, e.l}));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // Drives one start pulse; the edge that samples it is the latency reference.
    task automatic issue(input logic [19:0] a, input logic [19:0] b, input logic [2:0] o,
                         input logic sm, input logic s, input logic g, input logic e,
                         input logic l, input int lat, input bit push);
        exp_t x;
        register_A = a;
        register_B = b;
        op         = o;
`ifdef CMP_SIGNED_EN
        signed_mode = sm;
`else
        if (sm) $display("note: signed_mode ignored in unsigned build");
`endif
        start = 1'b1;
        @(posedge clk);
        if (push) begin
            x.s = s; x.g = g; x.e = e; x.l = l;
            x.t = $time + time'(lat * 10 + 5);
            q.push_back(x);
        end
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=%0d pending required=0", q.size());
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        register_A = '0;
        register_B = '0;
        op         = '0;
`ifdef CMP_SIGNED_EN
        signed_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_state", 64'({busy, done, sign_flag, gt_flag, eq_flag, lt_flag}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(20'hABCDE, 20'h54321, OP_GT, 1'b0, 1, 1, 0, 0, 2, 1'b1);
        #1 chk("busy_in_scan", 64'(busy), 64'd1);
        wait_idle();
        issue(20'h54321, 20'hABCDE, OP_GT, 1'b0, 0, 0, 0, 1, 2, 1'b1);
        wait_idle();
        issue(20'h54321, 20'hABCDE, OP_LE, 1'b0, 1, 0, 0, 1, 2, 1'b1);
        wait_idle();
        issue(20'h12345, 20'h12345, OP_EQ, 1'b0, 1, 0, 1, 0, 6, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("hold_flags", 64'({sign_flag, gt_flag, eq_flag, lt_flag}), 64'b1010);

        issue(20'h12345, 20'h12345, OP_NE, 1'b0, 0, 0, 1, 0, 6, 1'b1);
        #1 chk("clear_on_start", 64'({sign_flag, gt_flag, eq_flag, lt_flag}), 64'd0);
        wait_idle();
        issue(20'h12345, 20'h12346, OP_GE, 1'b0, 0, 0, 0, 1, 6, 1'b1);
        wait_idle();
        issue(20'h12945, 20'h12345, OP_LT, 1'b0, 0, 1, 0, 0, 4, 1'b1);
        wait_idle();
        issue(20'hF0000, 20'h00000, 3'd6, 1'b0, 0, 1, 0, 0, 2, 1'b1);
        wait_idle();
        issue(20'h00000, 20'h0F000, 3'd7, 1'b0, 0, 0, 0, 1, 3, 1'b1);
        wait_idle();
        issue(20'h80000, 20'h00001, OP_GT, 1'b0, 1, 1, 0, 0, 2, 1'b1);
        wait_idle();
`ifdef CMP_SIGNED_EN
        issue(20'h80000, 20'h00001, OP_GT, 1'b1, 0, 0, 0, 1, 2, 1'b1);
        wait_idle();
        issue(20'h80000, 20'h00001, OP_LT, 1'b1, 1, 0, 0, 1, 2, 1'b1);
        wait_idle();
`endif

        // Second start mid-scan with new operands must be dropped.
        issue(20'h12345, 20'h12345, OP_EQ, 1'b0, 1, 0, 1, 0, 6, 1'b1);
        @(posedge clk);
        #1;
        register_A = 20'hFFFFF;
        register_B = 20'h00000;
        op         = OP_GT;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_ignored_start", 64'(busy), 64'd1);
        wait_idle();
        chk("no_queued_op", 64'(busy), 64'd0);

        // Reset during the second scan cycle aborts without a done pulse.
        issue(20'h12345, 20'h12345, OP_EQ, 1'b0, 0, 0, 0, 0, 6, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 chk("abort_state", 64'({busy, done, sign_flag, gt_flag, eq_flag, lt_flag}), 64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_idle", 64'(busy), 64'd0);

        issue(20'hABCDE, 20'h54321, OP_GT, 1'b0, 1, 1, 0, 0, 2, 1'b1);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
